debug_trace: RTL and testbench



---
 rtl/debug_trace_pkg.sv | 9 +
 rtl/debug_trace_fifo.sv | 51 +++++
 rtl/debug_trace.sv | 86 ++++++++
 tb/tb_debug_trace.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/debug_trace_pkg.sv
// debug_trace_pkg: shared state encodings, record width and default halt pattern
package debug_trace_pkg;
  typedef enum logic [1:0] {S_RUN, S_BREAK, S_STEP, S_HALT} state_t;
  localparam logic [15:0] HLT_MASK_DEF = 16'hF001;
  localparam logic [15:0] HLT_VAL_DEF = 16'h7001;
  function automatic int rec_w(input int aw, input int dw);
    return 1 + aw + 2 * dw;
  endfunction
endpackage

// File: rtl/debug_trace_fifo.sv
// debug_trace_fifo: trace buffer with circular/stop-when-full modes and registered read
module debug_trace_fifo #(
  parameter int W = 45,
  parameter int DEPTH = 16,
  localparam int LW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  input  logic          mode,
  output logic [W-1:0]  dout,
  output logic          dvalid,
  output logic [LW:0]   count,
  output logic          empty,
  output logic          ovf
);
  logic [W-1:0] mem [DEPTH];
  logic [LW-1:0] wp, rp;
  logic full, pop_ok, wr, over, adv_rp;
  assign full = count == (LW+1)'(DEPTH);
  assign empty = count == '0;
  // full without a pop: mode 0 overwrites oldest (read pointer moves too), mode 1 drops
  always_comb begin
    pop_ok = pop && !empty;
    wr = push && (!full || pop_ok || !mode);
    over = wr && full && !pop_ok;
    adv_rp = pop_ok || over;
  end
  // storage needs no reset; only pointers define what is valid
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  // pointers, occupancy, sticky overflow and registered read port
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      ovf <= 1'b0;
      dout <= '0;
      dvalid <= 1'b0;
    end else begin
      wp <= wr ? wp + 1'b1 : wp;
      rp <= adv_rp ? rp + 1'b1 : rp;
      count <= count + (LW+1)'(wr) - (LW+1)'(adv_rp);
      ovf <= ovf | (push && full && !pop_ok);
      dout <= pop_ok ? mem[rp] : dout;
      dvalid <= pop_ok;
    end
endmodule

// File: rtl/debug_trace.sv
// debug_trace: uP16 debug monitor with trace capture, halt detect, breakpoints and single-step
module debug_trace import debug_trace_pkg::*; #(
  parameter int DW = 16,
  parameter int AW = 12,
  parameter int DEPTH = 16,
  parameter int NBRK = 2,
  parameter logic [DW-1:0] HLT_MASK = DW'(HLT_MASK_DEF),
  parameter logic [DW-1:0] HLT_VAL = DW'(HLT_VAL_DEF),
  localparam int RW = rec_w(AW, DW),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch,
  input  logic [AW-1:0]     pc,
  input  logic [DW-1:0]     ir,
  input  logic [DW-1:0]     ac,
  input  logic              e,
  input  logic [NBRK*AW-1:0] brk_addr,
  input  logic [NBRK-1:0]   brk_en,
  input  logic              resume,
  input  logic              step,
  input  logic              trc_mode,
  input  logic              rd_en,
  output logic [RW-1:0]     rd_data,
  output logic              rd_valid,
  output logic [CW-1:0]     trc_count,
  output logic              trc_empty,
  output logic              trc_ovf,
  output logic              stall,
  output logic              halted,
  output logic [NBRK-1:0]   brk_hit,
  output logic [31:0]       cyc_cnt
);
  state_t state, nxt;
  logic skip, live, is_hlt;
  logic [NBRK-1:0] match, first;
  assign live = state == S_RUN || state == S_STEP;
  assign is_hlt = (ir & HLT_MASK) == HLT_VAL;
  // breakpoint comparators, lowest matching slot isolated
  always_comb begin
    for (int k = 0; k < NBRK; k++) match[k] = brk_en[k] && pc == brk_addr[k*AW +: AW];
    first = match & (~match + NBRK'(1));
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_RUN;
    else state <= nxt;
  // next state: halt beats breakpoint, resume beats step, skip masks the post-resume fetch
  always_comb begin
    nxt = state;
    if (state == S_RUN && fetch) nxt = is_hlt ? S_HALT : (|match && !skip) ? S_BREAK : S_RUN;
    else if (state == S_STEP && fetch) nxt = is_hlt ? S_HALT : S_BREAK;
    else if (state == S_BREAK) nxt = resume ? S_RUN : step ? S_STEP : S_BREAK;
  end
  // outputs decoded from the registered state, so they follow the fetch edge by one cycle
  always_comb begin
    stall = state == S_BREAK || state == S_HALT;
    halted = state == S_HALT;
  end
  // brk_hit names the slot only for a RUN->BREAK trap; step-induced breaks report none
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) brk_hit <= '0;
    else brk_hit <= nxt == S_BREAK ? (state == S_RUN ? first : state == S_BREAK ? brk_hit : '0) : '0;
  // one-shot mask so the fetch right after resume cannot re-trap on the same pc
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) skip <= 1'b0;
    else skip <= (state == S_BREAK && resume) ? 1'b1 : fetch ? 1'b0 : skip;
  // saturating count of cycles spent executing
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cyc_cnt <= '0;
    else if (live && cyc_cnt != '1) cyc_cnt <= cyc_cnt + 1'b1;
  debug_trace_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(fetch && live),
    .din({e, pc, ir, ac}),
    .pop(rd_en),
    .mode(trc_mode),
    .dout(rd_data),
    .dvalid(rd_valid),
    .count(trc_count),
    .empty(trc_empty),
    .ovf(trc_ovf)
  );
endmodule

// File: tb/tb_debug_trace.sv
// tb_debug_trace: directed scenario tests for debug_trace
module tb_debug_trace;
  localparam int DW = 16, AW = 12, DEPTH = 16, NBRK = 2;
  localparam int CW = $clog2(DEPTH) + 1, RW = 1 + AW + 2 * DW;
  logic clk = 0, rst_n = 1, fetch = 0, e = 0, resume = 0, step = 0, trc_mode = 0, rd_en = 0;
  logic [AW-1:0] pc = '0;
  logic [DW-1:0] ir = '0, ac = '0;
  logic [NBRK*AW-1:0] brk_addr = '0;
  logic [NBRK-1:0] brk_en = '0;
  logic [RW-1:0] rd_data;
  logic rd_valid, trc_empty, trc_ovf, stall, halted;
  logic [CW-1:0] trc_count;
  logic [NBRK-1:0] brk_hit;
  logic [31:0] cyc_cnt;
  int tests = 0, fails = 0;

  debug_trace #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .NBRK(NBRK)) dut (
    .clk(clk), .rst_n(rst_n), .fetch(fetch), .pc(pc), .ir(ir), .ac(ac), .e(e),
    .brk_addr(brk_addr), .brk_en(brk_en), .resume(resume), .step(step),
    .trc_mode(trc_mode), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .trc_count(trc_count), .trc_empty(trc_empty), .trc_ovf(trc_ovf), .stall(stall),
    .halted(halted), .brk_hit(brk_hit), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ac_of(input logic [AW-1:0] p);
    return DW'(p) * 16'd3 ^ 16'h5A5A;
  endfunction

  function automatic logic [RW-1:0] rec(input logic [AW-1:0] p, input logic [DW-1:0] i);
    return {p[0], p, i, ac_of(p)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; fetch = 0; rd_en = 0; resume = 0; step = 0; brk_en = '0; brk_addr = '0; trc_mode = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic do_fetch(input logic [AW-1:0] p, input logic [DW-1:0] i);
    @(negedge clk);
    fetch = 1; pc = p; ir = i; ac = ac_of(p); e = p[0];
    @(negedge clk);
    fetch = 0;
  endtask

  task automatic do_pop();
    @(negedge clk);
    rd_en = 1;
    @(negedge clk);
    rd_en = 0;
  endtask

  task automatic pulse_ctl(input logic r, input logic s);
    @(negedge clk);
    resume = r; step = s;
    @(negedge clk);
    resume = 0; step = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %0b want 0", stall); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %0b want 0", halted); end
    tests++; if (brk_hit !== 2'b00) begin fails++; $display("FAIL reset_brk_hit: got %b want 00", brk_hit); end
    tests++; if (trc_count !== 5'd0 || trc_empty !== 1'b1 || trc_ovf !== 1'b0) begin fails++; $display("FAIL reset_fifo: count %0d empty %0b ovf %0b want 0 1 0", trc_count, trc_empty, trc_ovf); end
    tests++; if (rd_valid !== 1'b0 || rd_data !== '0) begin fails++; $display("FAIL reset_rd: valid %0b data %h want 0 0", rd_valid, rd_data); end
  endtask

  task automatic test_halt();
    logic [31:0] c0;
    do_reset();
    for (int i = 0; i < 5; i++) do_fetch(AW'(i), 16'h2000);
    tests++; if (halted !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL halt_pre: halted %0b stall %0b want 0 0", halted, stall); end
    do_fetch(12'h005, 16'h7001);
    tests++; if (halted !== 1'b1 || stall !== 1'b1) begin fails++; $display("FAIL halt_flag: halted %0b stall %0b want 1 1", halted, stall); end
    tests++; if (trc_count !== 5'd6) begin fails++; $display("FAIL halt_count: got %0d want 6", trc_count); end
    c0 = cyc_cnt;
    do_fetch(12'h006, 16'h2000);
    repeat (4) @(negedge clk);
    tests++; if (cyc_cnt !== c0 || trc_count !== 5'd6) begin fails++; $display("FAIL halt_frozen: cyc %0d count %0d want %0d 6", cyc_cnt, trc_count, c0); end
    for (int i = 0; i < 6; i++) begin
      do_pop();
      if (i == 0) begin tests++; if (rd_valid !== 1'b1 || rd_data !== rec(12'h000, 16'h2000)) begin fails++; $display("FAIL halt_first_rec: got %h want %h", rd_data, rec(12'h000, 16'h2000)); end end
      if (i == 5) begin tests++; if (rd_valid !== 1'b1 || rd_data !== rec(12'h005, 16'h7001)) begin fails++; $display("FAIL halt_last_rec: got %h want %h", rd_data, rec(12'h005, 16'h7001)); end end
    end
    do_pop();
    tests++; if (rd_valid !== 1'b0 || trc_count !== 5'd0 || trc_empty !== 1'b1) begin fails++; $display("FAIL empty_read: valid %0b count %0d want 0 0", rd_valid, trc_count); end
  endtask

  task automatic test_halt_mask();
    do_reset();
    do_fetch(12'h001, 16'h7000);
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL mask_nohalt: got %0b want 0", halted); end
    do_fetch(12'h002, 16'h7003);
    tests++; if (halted !== 1'b1) begin fails++; $display("FAIL mask_halt: got %0b want 1", halted); end
  endtask

  task automatic test_break_step();
    logic [31:0] c0;
    do_reset();
    brk_addr[0 +: AW] = 12'h003; brk_en = 2'b01;
    for (int i = 0; i < 4; i++) do_fetch(AW'(i), 16'h2000);
    tests++; if (stall !== 1'b1 || brk_hit !== 2'b01) begin fails++; $display("FAIL brk_trap: stall %0b hit %b want 1 01", stall, brk_hit); end
    tests++; if (trc_count !== 5'd4) begin fails++; $display("FAIL brk_count: got %0d want 4", trc_count); end
    c0 = cyc_cnt;
    do_fetch(12'h009, 16'h2000);
    tests++; if (trc_count !== 5'd4 || cyc_cnt !== c0) begin fails++; $display("FAIL brk_ignore: count %0d cyc %0d want 4 %0d", trc_count, cyc_cnt, c0); end
    pulse_ctl(0, 1);
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL step_release: got %0b want 0", stall); end
    do_fetch(12'h004, 16'h2000);
    tests++; if (stall !== 1'b1 || brk_hit !== 2'b00 || trc_count !== 5'd5) begin fails++; $display("FAIL step_rebreak: stall %0b hit %b count %0d want 1 00 5", stall, brk_hit, trc_count); end
    pulse_ctl(1, 0);
    tests++; if (stall !== 1'b0 || brk_hit !== 2'b00) begin fails++; $display("FAIL resume: stall %0b hit %b want 0 00", stall, brk_hit); end
    do_fetch(12'h003, 16'h2000);
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL no_retrap: got %0b want 0", stall); end
    do_fetch(12'h004, 16'h2000);
    tests++; if (stall !== 1'b0 || trc_count !== 5'd7) begin fails++; $display("FAIL free_run: stall %0b count %0d want 0 7", stall, trc_count); end
    do_fetch(12'h003, 16'h2000);
    tests++; if (stall !== 1'b1 || brk_hit !== 2'b01) begin fails++; $display("FAIL retrap_later: stall %0b hit %b want 1 01", stall, brk_hit); end
    pulse_ctl(1, 1);
    do_fetch(12'h009, 16'h2000);
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL resume_wins: got %0b want 0", stall); end
  endtask

  task automatic test_brk_priority();
    do_reset();
    brk_addr = {12'h010, 12'h010}; brk_en = 2'b11;
    do_fetch(12'h010, 16'h2000);
    tests++; if (brk_hit !== 2'b01 || stall !== 1'b1) begin fails++; $display("FAIL brk_lowest: hit %b stall %0b want 01 1", brk_hit, stall); end
    do_reset();
    brk_addr = {12'h010, 12'h010}; brk_en = 2'b10;
    do_fetch(12'h010, 16'h2000);
    tests++; if (brk_hit !== 2'b10) begin fails++; $display("FAIL brk_slot1: got %b want 10", brk_hit); end
    do_reset();
    brk_addr = {12'h010, 12'h010}; brk_en = 2'b00;
    do_fetch(12'h010, 16'h2000);
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL brk_disabled: got %0b want 0", stall); end
    do_reset();
    brk_addr = {12'h010, 12'h010}; brk_en = 2'b01;
    do_fetch(12'h010, 16'h7001);
    tests++; if (halted !== 1'b1 || brk_hit !== 2'b00) begin fails++; $display("FAIL halt_over_brk: halted %0b hit %b want 1 00", halted, brk_hit); end
  endtask

  task automatic test_overflow(input logic mode);
    do_reset();
    trc_mode = mode;
    for (int i = 0; i < 20; i++) do_fetch(AW'(i), 16'h2000);
    tests++; if (trc_count !== 5'd16 || trc_ovf !== 1'b1) begin fails++; $display("FAIL ovf_m%0b_state: count %0d ovf %0b want 16 1", mode, trc_count, trc_ovf); end
    do_pop();
    tests++; if (rd_data !== rec(mode ? 12'h000 : 12'h004, 16'h2000)) begin fails++; $display("FAIL ovf_m%0b_first: got %h want %h", mode, rd_data, rec(mode ? 12'h000 : 12'h004, 16'h2000)); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 16; i++) do_fetch(AW'(i), 16'h2000);
    tests++; if (trc_count !== 5'd16 || trc_ovf !== 1'b0) begin fails++; $display("FAIL exact_full: count %0d ovf %0b want 16 0", trc_count, trc_ovf); end
    @(negedge clk);
    fetch = 1; pc = 12'h100; ir = 16'h2000; ac = ac_of(12'h100); e = 0; rd_en = 1;
    @(negedge clk);
    fetch = 0; rd_en = 0;
    tests++; if (trc_count !== 5'd16 || trc_ovf !== 1'b0) begin fails++; $display("FAIL b2b_count: count %0d ovf %0b want 16 0", trc_count, trc_ovf); end
    tests++; if (rd_valid !== 1'b1 || rd_data !== rec(12'h000, 16'h2000)) begin fails++; $display("FAIL b2b_rd: valid %0b data %h want 1 %h", rd_valid, rd_data, rec(12'h000, 16'h2000)); end
    for (int i = 0; i < 16; i++) do_pop();
    tests++; if (rd_data !== rec(12'h100, 16'h2000) || trc_empty !== 1'b1) begin fails++; $display("FAIL b2b_last: data %h empty %0b want %h 1", rd_data, trc_empty, rec(12'h100, 16'h2000)); end
  endtask

  task automatic test_async_reset();
    do_reset();
    brk_addr[0 +: AW] = 12'h006; brk_en = 2'b01;
    for (int i = 0; i < 7; i++) do_fetch(AW'(i), 16'h2000);
    tests++; if (stall !== 1'b1 || trc_count !== 5'd7) begin fails++; $display("FAIL ar_setup: stall %0b count %0d want 1 7", stall, trc_count); end
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    tests++; if (stall !== 1'b0 || trc_count !== 5'd0 || trc_ovf !== 1'b0 || cyc_cnt !== 32'd0 || brk_hit !== 2'b00) begin fails++; $display("FAIL async_reset: stall %0b count %0d ovf %0b cyc %0d hit %b want 0 0 0 0 00", stall, trc_count, trc_ovf, cyc_cnt, brk_hit); end
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_halt();
    test_halt_mask();
    test_break_step();
    test_brk_priority();
    test_overflow(1'b0);
    test_overflow(1'b1);
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
